threshold_monitor: RTL and testbench
====================================

THRESHOLD_MONITOR -- requirements
Module: threshold_monitor

Interface
REQ-001 SHALL have parameter width, default 8: bit width of sample and limits.
REQ-002 SHALL have parameter holdoff, default 3: consecutive above-limit valid samples needed to raise alarm; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  sample qualifier; sample is consumed in any cycle where in_valid=1.
REQ-006 SHALL have port sample  input  width  unsigned sample value.
REQ-007 SHALL have port hi_limit  input  width  unsigned upper threshold, compared strictly (sample > hi_limit).
REQ-008 SHALL have port lo_limit  input  width  unsigned lower threshold, compared strictly (sample < lo_limit).
REQ-009 SHALL have port clear  input  1  synchronous software clear of alarm and run state.
REQ-010 SHALL have port above  output  1  registered result of sample > hi_limit for the last consumed sample.
REQ-011 SHALL have port below  output  1  registered result of sample < lo_limit for the last consumed sample.
REQ-012 SHALL have port alarm  output  1  registered alarm state.
REQ-013 SHALL have port peak  output  width  largest sample consumed while in ALARM (including the entry sample).
REQ-014 SHALL have port events  output  8  count of ALARM entries, saturating at 255.

Function
REQ-015 SHALL implement states NORMAL, PENDING, ALARM plus 4-bit run counter run_cnt.
REQ-016 SHALL leave all state and outputs unchanged in cycles with in_valid=0 and clear=0.
REQ-017 SHALL, on each consumed sample, update above and below at that edge; outputs valid one cycle after in_valid (latency 1).
REQ-018 NORMAL: consumed sample with above condition -> PENDING, run_cnt=1; if holdoff=1 go directly to ALARM instead.
REQ-019 PENDING: above condition -> run_cnt+1; when run_cnt+1 equals holdoff -> ALARM, run_cnt=0; non-above sample -> NORMAL, run_cnt=0.
REQ-020 ALARM: consumed sample with below condition -> NORMAL; any other sample (including above or in-window) stays ALARM (hysteresis).
REQ-021 SHALL assert alarm at the same edge the FSM enters ALARM and deassert at the edge it leaves; alarm = (state==ALARM).
REQ-022 SHALL load peak with the entry sample on ALARM entry, and while in ALARM update peak = max(peak, sample) per consumed sample; peak holds its value after exit until next entry.
REQ-023 SHALL increment events by 1 on each ALARM entry; at 255 it stays 255.
REQ-024 SHALL evaluate a sample satisfying both above and below (lo_limit > hi_limit) as above in NORMAL/PENDING and as below in ALARM.
REQ-025 clear=1 SHALL force NORMAL, run_cnt=0, alarm=0, above=0, below=0 at the next edge, overriding a simultaneous valid sample; peak and events are retained.
REQ-026 Limit changes SHALL take effect on the next consumed sample; no state is reset by a limit change.

Reset
REQ-027 reset=1 at a rising edge SHALL force state NORMAL, run_cnt=0, above=0, below=0, alarm=0, peak=0, events=0.
REQ-028 reset SHALL take priority over clear and in_valid, including mid-PENDING or mid-ALARM.
REQ-029 No output SHALL change asynchronously to clk.

Verification (holdoff=3, width=8, hi_limit=200, lo_limit=100 unless stated)
REQ-030 Samples 210,220,230 on consecutive valid cycles -> alarm=1 after third edge, events=1, peak=230; above=1 each cycle.
REQ-031 Samples 210,220,150,230 -> no alarm; run broken by 150 (state NORMAL, run_cnt=0 after third edge), 230 restarts PENDING.
REQ-032 In ALARM feed 150, 250, 90 -> alarm stays 1 through 150 and 250 (peak=250), clears after 90 with below=1; peak stays 250.
REQ-033 Samples 210,220 with in_valid=0 gaps of 5 cycles between, then 230 -> alarm=1; gaps do not break the run.
REQ-034 In PENDING, assert clear together with valid sample 240 -> state NORMAL, alarm=0, above=0; then reset mid-ALARM -> all outputs 0 next edge.
REQ-035 holdoff=1: 256 alarm entry/exit cycles (201 then 99) -> events saturates at 255; boundary samples 200 and 100 -> above=0, below=0.

Source files
------------

// File: rtl/threshold_monitor.sv
// Threshold monitor: flags a run of consecutive above-limit samples as an alarm,
// holds it with hysteresis until a below-limit sample, and tracks peak and entry count.
module threshold_monitor #(
  parameter int width   = 8,
  parameter int holdoff = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [width-1:0] sample,
  input  logic [width-1:0] hi_limit,
  input  logic [width-1:0] lo_limit,
  input  logic             clear,
  output logic             above,
  output logic             below,
  output logic             alarm,
  output logic [width-1:0] peak,
  output logic [7:0]       events
);

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;
  localparam logic [3:0] HOLD       = 4'(holdoff);

  logic [1:0]       r_state;
  logic [3:0]       r_run_cnt;
  logic             r_above;
  logic             r_below;
  logic [width-1:0] r_peak;
  logic [7:0]       r_events;

  logic             w_above;
  logic             w_below;
  logic [1:0]       w_state_next;
  logic [3:0]       w_run_next;
  logic             w_enter;

  // A sample that is both above and below counts as above outside ALARM
  // and as below inside ALARM, which falls out of the per-state checks.
  always_comb begin
    w_above      = (sample > hi_limit);
    w_below      = (sample < lo_limit);
    w_state_next = r_state;
    w_run_next   = r_run_cnt;
    w_enter      = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_above) begin
          if (HOLD == 4'd1) begin
            w_state_next = ST_ALARM;
            w_run_next   = 4'd0;
            w_enter      = 1'b1;
          end else begin
            w_state_next = ST_PENDING;
            w_run_next   = 4'd1;
          end
        end
      end
      ST_PENDING: begin
        if (w_above) begin
          if ((r_run_cnt + 4'd1) == HOLD) begin
            w_state_next = ST_ALARM;
            w_run_next   = 4'd0;
            w_enter      = 1'b1;
          end else begin
            w_run_next = r_run_cnt + 4'd1;
          end
        end else begin
          w_state_next = ST_NORMAL;
          w_run_next   = 4'd0;
        end
      end
      ST_ALARM: begin
        if (w_below) begin
          w_state_next = ST_NORMAL;
          w_run_next   = 4'd0;
        end
      end
      default: begin
        w_state_next = ST_NORMAL;
        w_run_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_NORMAL;
      r_run_cnt <= 4'd0;
      r_above   <= 1'b0;
      r_below   <= 1'b0;
      r_peak    <= '0;
      r_events  <= 8'd0;
    end else if (clear) begin
      // Peak and event count survive a software clear.
      r_state   <= ST_NORMAL;
      r_run_cnt <= 4'd0;
      r_above   <= 1'b0;
      r_below   <= 1'b0;
    end else if (in_valid) begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_next;
      r_above   <= w_above;
      r_below   <= w_below;
      if (w_enter) begin
        r_peak <= sample;
        if (r_events != 8'd255) r_events <= r_events + 8'd1;
      end else if ((r_state == ST_ALARM) && (sample > r_peak)) begin
        r_peak <= sample;
      end
    end
  end

  assign above  = r_above;
  assign below  = r_below;
  assign alarm  = (r_state == ST_ALARM);
  assign peak   = r_peak;
  assign events = r_events;

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed bench for threshold_monitor: one instance with holdoff=3, one with holdoff=1,
// sharing stimulus; each task checks its scenario against hand-computed values.
module tb_threshold_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] sample = 8'd0;
  logic [7:0] hi_limit = 8'd200;
  logic [7:0] lo_limit = 8'd100;
  logic       clear = 1'b0;

  logic       above3, below3, alarm3;
  logic [7:0] peak3, events3;
  logic       above1, below1, alarm1;
  logic [7:0] peak1, events1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  threshold_monitor #(.width(8), .holdoff(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sample(sample),
    .hi_limit(hi_limit), .lo_limit(lo_limit), .clear(clear),
    .above(above3), .below(below3), .alarm(alarm3), .peak(peak3), .events(events3)
  );

  threshold_monitor #(.width(8), .holdoff(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sample(sample),
    .hi_limit(hi_limit), .lo_limit(lo_limit), .clear(clear),
    .above(above1), .below(below1), .alarm(alarm1), .peak(peak1), .events(events1)
  );

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic send(input logic v, input logic [7:0] s, input logic c);
    in_valid = v;
    sample   = s;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    $display("txn v=%0b s=%0d clr=%0b | h3: ab=%0b be=%0b al=%0b pk=%0d ev=%0d | h1: al=%0b ev=%0d",
             v, s, c, above3, below3, alarm3, peak3, events3, alarm1, events1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    send(1'b1, 8'd250, 1'b0);
    do_reset();
    checks++; if (above3 !== 1'b0)  begin errors++; $display("FAIL reset_above: got %0b want 0", above3); end
    checks++; if (below3 !== 1'b0)  begin errors++; $display("FAIL reset_below: got %0b want 0", below3); end
    checks++; if (alarm3 !== 1'b0)  begin errors++; $display("FAIL reset_alarm: got %0b want 0", alarm3); end
    checks++; if (peak3 !== 8'd0)   begin errors++; $display("FAIL reset_peak: got %0d want 0", peak3); end
    checks++; if (events3 !== 8'd0) begin errors++; $display("FAIL reset_events: got %0d want 0", events3); end
    checks++; if (alarm1 !== 1'b0)  begin errors++; $display("FAIL reset_alarm_h1: got %0b want 0", alarm1); end
  endtask

  task automatic test_basic_alarm();
    do_reset();
    send(1'b1, 8'd210, 1'b0);
    checks++; if (above3 !== 1'b1) begin errors++; $display("FAIL basic_above1: got %0b want 1", above3); end
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL basic_alarm1: got %0b want 0", alarm3); end
    send(1'b1, 8'd220, 1'b0);
    checks++; if (above3 !== 1'b1) begin errors++; $display("FAIL basic_above2: got %0b want 1", above3); end
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL basic_alarm2: got %0b want 0", alarm3); end
    send(1'b1, 8'd230, 1'b0);
    checks++; if (above3 !== 1'b1)  begin errors++; $display("FAIL basic_above3: got %0b want 1", above3); end
    checks++; if (alarm3 !== 1'b1)  begin errors++; $display("FAIL basic_alarm3: got %0b want 1", alarm3); end
    checks++; if (events3 !== 8'd1) begin errors++; $display("FAIL basic_events: got %0d want 1", events3); end
    checks++; if (peak3 !== 8'd230) begin errors++; $display("FAIL basic_peak: got %0d want 230", peak3); end
  endtask

  task automatic test_run_break();
    do_reset();
    send(1'b1, 8'd210, 1'b0);
    send(1'b1, 8'd220, 1'b0);
    send(1'b1, 8'd150, 1'b0);
    checks++; if (above3 !== 1'b0) begin errors++; $display("FAIL break_above: got %0b want 0", above3); end
    checks++; if (below3 !== 1'b0) begin errors++; $display("FAIL break_below: got %0b want 0", below3); end
    send(1'b1, 8'd230, 1'b0);
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL break_restart1: got %0b want 0", alarm3); end
    send(1'b1, 8'd240, 1'b0);
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL break_restart2: got %0b want 0", alarm3); end
    send(1'b1, 8'd250, 1'b0);
    checks++; if (alarm3 !== 1'b1)  begin errors++; $display("FAIL break_restart3: got %0b want 1", alarm3); end
    checks++; if (peak3 !== 8'd250) begin errors++; $display("FAIL break_peak: got %0d want 250", peak3); end
  endtask

  task automatic test_hysteresis();
    do_reset();
    send(1'b1, 8'd210, 1'b0);
    send(1'b1, 8'd220, 1'b0);
    send(1'b1, 8'd230, 1'b0);
    send(1'b1, 8'd150, 1'b0);
    checks++; if (alarm3 !== 1'b1)  begin errors++; $display("FAIL hyst_alarm150: got %0b want 1", alarm3); end
    checks++; if (peak3 !== 8'd230) begin errors++; $display("FAIL hyst_peak150: got %0d want 230", peak3); end
    send(1'b1, 8'd250, 1'b0);
    checks++; if (alarm3 !== 1'b1)  begin errors++; $display("FAIL hyst_alarm250: got %0b want 1", alarm3); end
    checks++; if (peak3 !== 8'd250) begin errors++; $display("FAIL hyst_peak250: got %0d want 250", peak3); end
    send(1'b1, 8'd90, 1'b0);
    checks++; if (alarm3 !== 1'b0)  begin errors++; $display("FAIL hyst_alarm90: got %0b want 0", alarm3); end
    checks++; if (below3 !== 1'b1)  begin errors++; $display("FAIL hyst_below90: got %0b want 1", below3); end
    checks++; if (peak3 !== 8'd250) begin errors++; $display("FAIL hyst_peak90: got %0d want 250", peak3); end
    checks++; if (events3 !== 8'd1) begin errors++; $display("FAIL hyst_events: got %0d want 1", events3); end
    send(1'b1, 8'd180, 1'b0);
    checks++; if (peak3 !== 8'd250) begin errors++; $display("FAIL hyst_peak_hold: got %0d want 250", peak3); end
  endtask

  task automatic test_gaps();
    do_reset();
    send(1'b1, 8'd210, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 8'd50, 1'b0);
    checks++; if (above3 !== 1'b1) begin errors++; $display("FAIL gap_above_hold: got %0b want 1", above3); end
    checks++; if (below3 !== 1'b0) begin errors++; $display("FAIL gap_below_hold: got %0b want 0", below3); end
    send(1'b1, 8'd220, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 8'd50, 1'b0);
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL gap_alarm_early: got %0b want 0", alarm3); end
    send(1'b1, 8'd230, 1'b0);
    checks++; if (alarm3 !== 1'b1)  begin errors++; $display("FAIL gap_alarm: got %0b want 1", alarm3); end
    checks++; if (events3 !== 8'd1) begin errors++; $display("FAIL gap_events: got %0d want 1", events3); end
  endtask

  task automatic test_clear();
    do_reset();
    send(1'b1, 8'd210, 1'b0);
    send(1'b1, 8'd220, 1'b0);
    send(1'b1, 8'd240, 1'b1);
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL clear_alarm: got %0b want 0", alarm3); end
    checks++; if (above3 !== 1'b0) begin errors++; $display("FAIL clear_above: got %0b want 0", above3); end
    send(1'b1, 8'd250, 1'b0);
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL clear_run_reset: got %0b want 0", alarm3); end
    send(1'b1, 8'd210, 1'b0);
    send(1'b1, 8'd220, 1'b0);
    checks++; if (alarm3 !== 1'b1)  begin errors++; $display("FAIL clear_realarm: got %0b want 1", alarm3); end
    checks++; if (peak3 !== 8'd220) begin errors++; $display("FAIL clear_entry_peak: got %0d want 220", peak3); end
    send(1'b0, 8'd0, 1'b1);
    checks++; if (alarm3 !== 1'b0)  begin errors++; $display("FAIL clear_in_alarm: got %0b want 0", alarm3); end
    checks++; if (peak3 !== 8'd220) begin errors++; $display("FAIL clear_keep_peak: got %0d want 220", peak3); end
    checks++; if (events3 !== 8'd1) begin errors++; $display("FAIL clear_keep_events: got %0d want 1", events3); end
    send(1'b1, 8'd210, 1'b0);
    send(1'b1, 8'd220, 1'b0);
    send(1'b1, 8'd230, 1'b0);
    checks++; if (events3 !== 8'd2) begin errors++; $display("FAIL clear_events2: got %0d want 2", events3); end
    // Reset wins over simultaneous clear and valid sample while in ALARM.
    reset = 1'b1; in_valid = 1'b1; sample = 8'd240; clear = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; clear = 1'b0;
    $display("txn reset-mid-alarm | h3: ab=%0b be=%0b al=%0b pk=%0d ev=%0d", above3, below3, alarm3, peak3, events3);
    checks++; if (alarm3 !== 1'b0)  begin errors++; $display("FAIL rst_alarm: got %0b want 0", alarm3); end
    checks++; if (above3 !== 1'b0)  begin errors++; $display("FAIL rst_above: got %0b want 0", above3); end
    checks++; if (peak3 !== 8'd0)   begin errors++; $display("FAIL rst_peak: got %0d want 0", peak3); end
    checks++; if (events3 !== 8'd0) begin errors++; $display("FAIL rst_events: got %0d want 0", events3); end
  endtask

  task automatic test_overlap_limits();
    do_reset();
    hi_limit = 8'd100;
    lo_limit = 8'd200;
    send(1'b1, 8'd150, 1'b0);
    checks++; if (above3 !== 1'b1 || below3 !== 1'b1) begin errors++; $display("FAIL overlap_flags: got ab=%0b be=%0b want 1 1", above3, below3); end
    send(1'b1, 8'd150, 1'b0);
    send(1'b1, 8'd150, 1'b0);
    checks++; if (alarm3 !== 1'b1) begin errors++; $display("FAIL overlap_enter: got %0b want 1", alarm3); end
    send(1'b1, 8'd150, 1'b0);
    checks++; if (alarm3 !== 1'b0) begin errors++; $display("FAIL overlap_exit: got %0b want 0", alarm3); end
    hi_limit = 8'd200;
    lo_limit = 8'd100;
  endtask

  task automatic test_holdoff1();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(1'b1, 8'd201, 1'b0);
      if (i == 0 || i == 255) begin
        checks++; if (alarm1 !== 1'b1) begin errors++; $display("FAIL h1_enter_%0d: got %0b want 1", i, alarm1); end
      end
      if (i == 0) begin
        checks++; if (events1 !== 8'd1) begin errors++; $display("FAIL h1_events_first: got %0d want 1", events1); end
      end
      if (i == 254) begin
        checks++; if (events1 !== 8'd255) begin errors++; $display("FAIL h1_events_255: got %0d want 255", events1); end
      end
      send(1'b1, 8'd99, 1'b0);
    end
    checks++; if (events1 !== 8'd255) begin errors++; $display("FAIL h1_events_sat: got %0d want 255", events1); end
    checks++; if (alarm1 !== 1'b0)    begin errors++; $display("FAIL h1_exit: got %0b want 0", alarm1); end
    send(1'b1, 8'd200, 1'b0);
    checks++; if (above1 !== 1'b0 || below1 !== 1'b0) begin errors++; $display("FAIL h1_bound200: got ab=%0b be=%0b want 0 0", above1, below1); end
    checks++; if (alarm1 !== 1'b0) begin errors++; $display("FAIL h1_bound200_alarm: got %0b want 0", alarm1); end
    send(1'b1, 8'd100, 1'b0);
    checks++; if (above1 !== 1'b0 || below1 !== 1'b0) begin errors++; $display("FAIL h1_bound100: got ab=%0b be=%0b want 0 0", above1, below1); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic_alarm();
    test_run_break();
    test_hysteresis();
    test_gaps();
    test_clear();
    test_overlap_limits();
    test_holdoff1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
